// File: rtl/peripheral_bus_transaction_initiator.sv
// -----------------------------------------------------------------------------
// peripheral_bus_transaction_initiator
//
// Upstream end of the chip-select / data-valid peripheral bus. Host words are
// buffered in a small FIFO; each word becomes one bus transaction (select,
// one-cycle data strobe, wait for complete/error). Failed attempts are
// re-driven up to MAX_RETRY_COUNT times, after which the word is dropped and
// a sticky failure flag is raised.
//
// Ports:
//   system_main_clock                   - sole clock, rising edge
//   asynchronous_reset_active_low_n     - asynchronous active-low reset
//   write_data_from_host_module         - host payload
//   write_valid_from_host_module        - host push request
//   write_ready_to_host_module          - FIFO not full
//   peripheral_bus_chip_select_n        - active-low chip select (registered)
//   data_valid_to_downstream_module     - one-cycle payload strobe (registered)
//   data_payload_to_downstream_module   - payload, valid with strobe (registered)
//   transaction_complete_status_flag    - downstream success response
//   error_condition_detected_indicator  - downstream error response
//   fifo_almost_full_threshold_reached  - occupancy >= ALMOST_FULL_THRESHOLD
//   fifo_almost_empty_threshold_reached - occupancy <= ALMOST_EMPTY_THRESHOLD
//   fifo_occupancy_count                - words held in the FIFO
//   transaction_failed_sticky_flag      - a word was dropped after retries
//   transaction_failed_clear_pulse      - clears the sticky flag
// -----------------------------------------------------------------------------
module peripheral_bus_transaction_initiator #(
    parameter int DATA_WIDTH              = 8,
    parameter int FIFO_DEPTH              = 8,
    parameter int ALMOST_FULL_THRESHOLD   = 6,
    parameter int ALMOST_EMPTY_THRESHOLD  = 2,
    parameter int RESPONSE_TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRY_COUNT         = 2
) (
    input  logic                          system_main_clock,
    input  logic                          asynchronous_reset_active_low_n,
    input  logic [DATA_WIDTH-1:0]         write_data_from_host_module,
    input  logic                          write_valid_from_host_module,
    output logic                          write_ready_to_host_module,
    output logic                          peripheral_bus_chip_select_n,
    output logic                          data_valid_to_downstream_module,
    output logic [DATA_WIDTH-1:0]         data_payload_to_downstream_module,
    input  logic                          transaction_complete_status_flag,
    input  logic                          error_condition_detected_indicator,
    output logic                          fifo_almost_full_threshold_reached,
    output logic                          fifo_almost_empty_threshold_reached,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_occupancy_count,
    output logic                          transaction_failed_sticky_flag,
    input  logic                          transaction_failed_clear_pulse
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TO_W    = $clog2(RESPONSE_TIMEOUT_CYCLES + 1);
    localparam int RETRY_W = (MAX_RETRY_COUNT > 0) ? $clog2(MAX_RETRY_COUNT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_DRIVE,
        S_WAIT_RESPONSE,
        S_RELEASE
    } state_t;

    state_t state, next_state;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [TO_W-1:0]       timeout_cnt;
    logic [RETRY_W-1:0]    retry_cnt;

    logic push, pop, drop, retry, timeout_hit;

    // Handshake and status flags decode the registered occupancy count.
    assign write_ready_to_host_module          = (count != CNT_W'(FIFO_DEPTH));
    assign fifo_almost_full_threshold_reached  = (count >= CNT_W'(ALMOST_FULL_THRESHOLD));
    assign fifo_almost_empty_threshold_reached = (count <= CNT_W'(ALMOST_EMPTY_THRESHOLD));
    assign fifo_occupancy_count                = count;

    assign push        = write_valid_from_host_module && write_ready_to_host_module;
    assign timeout_hit = (timeout_cnt == TO_W'(RESPONSE_TIMEOUT_CYCLES - 1));

    // Next-state and transaction control.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        next_state = state;
        pop        = 1'b0;
        drop       = 1'b0;
        retry      = 1'b0;
        case (state)
            S_IDLE:   if (count != '0) next_state = S_SELECT;
            S_SELECT: next_state = S_DRIVE;
            S_DRIVE:  next_state = S_WAIT_RESPONSE;
            S_WAIT_RESPONSE: begin
                // A clean completion wins over a timeout on the same cycle;
                // error (alone or with complete) is always a failure.
                if (transaction_complete_status_flag && !error_condition_detected_indicator) begin
                    pop        = 1'b1;
                    next_state = S_RELEASE;
                end else if (error_condition_detected_indicator || timeout_hit) begin
                    if (retry_cnt < RETRY_W'(MAX_RETRY_COUNT)) begin
                        retry      = 1'b1;
                        next_state = S_DRIVE;
                    end else begin
                        pop        = 1'b1;
                        drop       = 1'b1;
                        next_state = S_RELEASE;
                    end
                end
            end
            S_RELEASE: next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // State register, registered bus outputs (decoded from next_state so they
    // line up with the state they belong to), and transaction counters.
    always_ff @(posedge system_main_clock or negedge asynchronous_reset_active_low_n) begin
        if (!asynchronous_reset_active_low_n) begin
            state                             <= S_IDLE;
            peripheral_bus_chip_select_n      <= 1'b1;
            data_valid_to_downstream_module   <= 1'b0;
            data_payload_to_downstream_module <= '0;
            timeout_cnt                       <= '0;
            retry_cnt                         <= '0;
            transaction_failed_sticky_flag    <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state                           <= next_state;
            peripheral_bus_chip_select_n    <= (next_state == S_IDLE) || (next_state == S_RELEASE);
            data_valid_to_downstream_module <= (next_state == S_DRIVE);
            data_payload_to_downstream_module <= (next_state == S_DRIVE) ? mem[rd_ptr] : '0;

            if (state == S_DRIVE)
                timeout_cnt <= '0;
            else if (state == S_WAIT_RESPONSE)
                timeout_cnt <= timeout_cnt + TO_W'(1);

            if (state == S_RELEASE)
                retry_cnt <= '0;
            else if (retry)
                retry_cnt <= retry_cnt + RETRY_W'(1);

            // Set beats clear when both land on the same cycle.
            if (drop)
                transaction_failed_sticky_flag <= 1'b1;
            else if (transaction_failed_clear_pulse)
                transaction_failed_sticky_flag <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge system_main_clock or negedge asynchronous_reset_active_low_n) begin
        if (!asynchronous_reset_active_low_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are meaningful, so clearing the data itself is unneeded.
    always_ff @(posedge system_main_clock) begin
        if (push) mem[wr_ptr] <= write_data_from_host_module;
    end

endmodule

// File: tb/tb_peripheral_bus_transaction_initiator.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for peripheral_bus_transaction_initiator.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_peripheral_bus_transaction_initiator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       wvalid = 1'b0;
    logic       ready;
    logic       cs_n;
    logic       dv;
    logic [7:0] payload;
    logic       complete = 1'b0;
    logic       error = 1'b0;
    logic       afull;
    logic       aempty;
    logic [3:0] count;
    logic       failed;
    logic       clear = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    peripheral_bus_transaction_initiator dut (
        .system_main_clock                   (clk),
        .asynchronous_reset_active_low_n     (rst_n),
        .write_data_from_host_module         (wdata),
        .write_valid_from_host_module        (wvalid),
        .write_ready_to_host_module          (ready),
        .peripheral_bus_chip_select_n        (cs_n),
        .data_valid_to_downstream_module     (dv),
        .data_payload_to_downstream_module   (payload),
        .transaction_complete_status_flag    (complete),
        .error_condition_detected_indicator  (error),
        .fifo_almost_full_threshold_reached  (afull),
        .fifo_almost_empty_threshold_reached (aempty),
        .fifo_occupancy_count                (count),
        .transaction_failed_sticky_flag      (failed),
        .transaction_failed_clear_pulse      (clear)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the data strobe is seen or the cycle budget runs out.
    task automatic wait_strobe(input int budget, output bit seen, output int cycles);
        cycles = 0;
        while (dv !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        seen = (dv === 1'b1);
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_cmp++;
        if ({cs_n, dv, payload} !== {1'b1, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_bus: got cs_n/dv/payload=%b/%b/%h want 1/0/00", cs_n, dv, payload);
        end
        n_cmp++;
        if ({ready, aempty, afull, count, failed} !== {1'b1, 1'b1, 1'b0, 4'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_status: got ready/ae/af/count/failed=%b/%b/%b/%0d/%b want 1/1/0/0/0",
                     ready, aempty, afull, count, failed);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({cs_n, dv, count} !== {1'b1, 1'b0, 4'd0}) begin
            n_bad++;
            $display("FAIL reset_release: got cs_n/dv/count=%b/%b/%0d want 1/0/0", cs_n, dv, count);
        end
    endtask

    task automatic test_single();
        wdata = 8'hA5; wvalid = 1'b1;
        tick();                                     // E0: pushed
        wvalid = 1'b0;
        n_cmp++;
        if ({count, cs_n} !== {4'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL single_push: got count/cs_n=%0d/%b want 1/1", count, cs_n);
        end
        tick();                                     // E1: SELECT
        n_cmp++;
        if ({cs_n, dv} !== {1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL single_select: got cs_n/dv=%b/%b want 0/0", cs_n, dv);
        end
        tick();                                     // E2: DRIVE
        n_cmp++;
        if ({cs_n, dv, payload} !== {1'b0, 1'b1, 8'hA5}) begin
            n_bad++;
            $display("FAIL single_drive: got cs_n/dv/payload=%b/%b/%h want 0/1/a5", cs_n, dv, payload);
        end
        tick();                                     // E3: WAIT cycle 0
        n_cmp++;
        if ({cs_n, dv, count} !== {1'b0, 1'b0, 4'd1}) begin
            n_bad++;
            $display("FAIL single_wait: got cs_n/dv/count=%b/%b/%0d want 0/0/1", cs_n, dv, count);
        end
        tick();                                     // E4: WAIT cycle 1
        complete = 1'b1;
        tick();                                     // E5: pop, RELEASE
        complete = 1'b0;
        n_cmp++;
        if ({cs_n, count, aempty} !== {1'b1, 4'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL single_release: got cs_n/count/ae=%b/%0d/%b want 1/0/1", cs_n, count, aempty);
        end
        repeat (2) tick();                          // IDLE with empty FIFO
        n_cmp++;
        if ({cs_n, dv} !== {1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL single_idle: got cs_n/dv=%b/%b want 1/0", cs_n, dv);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [9];
        bit         seen;
        int         cyc;
        logic [3:0] exp_cnt;
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};

        wdata = words[0]; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        wait_strobe(8, seen, cyc);
        n_cmp++;
        if (!seen || payload !== words[0]) begin
            n_bad++;
            $display("FAIL b2b_first: got seen/payload=%b/%h want 1/%h", seen, payload, words[0]);
        end
        tick();                                     // WAIT cycle 0, count 1
        for (int i = 1; i < 9; i++) begin
            wdata = words[i]; wvalid = 1'b1;
            n_cmp++;
            if (ready !== (i < 8)) begin
                n_bad++;
                $display("FAIL b2b_ready_%0d: got %b want %b", i, ready, (i < 8));
            end
            tick();
            exp_cnt = (i < 8) ? 4'(i + 1) : 4'd8;
            n_cmp++;
            if ({count, afull} !== {exp_cnt, (exp_cnt >= 4'd6)}) begin
                n_bad++;
                $display("FAIL b2b_fill_%0d: got count/af=%0d/%b want %0d/%b",
                         i, count, afull, exp_cnt, (exp_cnt >= 4'd6));
            end
        end
        wvalid = 1'b0;
        complete = 1'b1;
        tick();                                     // first word popped
        complete = 1'b0;
        n_cmp++;
        if ({count, cs_n} !== {4'd7, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_pop: got count/cs_n=%0d/%b want 7/1", count, cs_n);
        end
        tick();                                     // IDLE: second high cycle
        n_cmp++;
        if (cs_n !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_gap_idle: got cs_n=%b want 1", cs_n);
        end
        tick();                                     // SELECT
        n_cmp++;
        if (cs_n !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_gap_select: got cs_n=%b want 0", cs_n);
        end
        for (int i = 1; i < 8; i++) begin
            wait_strobe(8, seen, cyc);
            n_cmp++;
            if (!seen || payload !== words[i]) begin
                n_bad++;
                $display("FAIL b2b_order_%0d: got seen/payload=%b/%h want 1/%h", i, seen, payload, words[i]);
            end
            tick();
            complete = 1'b1;
            tick();
            complete = 1'b0;
        end
        n_cmp++;
        if (count !== 4'd0) begin
            n_bad++;
            $display("FAIL b2b_drained: got count=%0d want 0", count);
        end
        wait_strobe(10, seen, cyc);
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL b2b_ninth_dropped: got strobe with payload %h want none", payload);
        end
    endtask

    task automatic test_retry();
        bit seen;
        int cyc;
        wdata = 8'h3C; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int a = 0; a < 3; a++) begin
            wait_strobe(8, seen, cyc);
            n_cmp++;
            if (!seen || {cs_n, payload} !== {1'b0, 8'h3C}) begin
                n_bad++;
                $display("FAIL retry_drive_%0d: got seen/cs_n/payload=%b/%b/%h want 1/0/3c", a, seen, cs_n, payload);
            end
            if (a > 0) begin
                n_cmp++;
                if (cyc !== 0) begin
                    n_bad++;
                    $display("FAIL retry_immediate_%0d: got %0d cycles want 0", a, cyc);
                end
            end
            tick();                                 // WAIT cycle 0
            n_cmp++;
            if ({cs_n, count} !== {1'b0, 4'd1}) begin
                n_bad++;
                $display("FAIL retry_wait_%0d: got cs_n/count=%b/%0d want 0/1", a, cs_n, count);
            end
            if (a < 2) error = 1'b1;
            else       complete = 1'b1;
            tick();
            error = 1'b0; complete = 1'b0;
        end
        n_cmp++;
        if ({cs_n, count, failed} !== {1'b1, 4'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL retry_done: got cs_n/count/failed=%b/%0d/%b want 1/0/0", cs_n, count, failed);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int cyc;
        wdata = 8'h5A; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        wait_strobe(8, seen, cyc);
        n_cmp++;
        if (!seen || payload !== 8'h5A) begin
            n_bad++;
            $display("FAIL timeout_drive_0: got seen/payload=%b/%h want 1/5a", seen, payload);
        end
        for (int k = 1; k < 3; k++) begin
            tick();
            wait_strobe(40, seen, cyc);
            n_cmp++;
            if (!seen || cyc !== 16 || {cs_n, payload} !== {1'b0, 8'h5A}) begin
                n_bad++;
                $display("FAIL timeout_redrive_%0d: got seen/gap/cs_n/payload=%b/%0d/%b/%h want 1/16/0/5a",
                         k, seen, cyc, cs_n, payload);
            end
        end
        repeat (16) tick();                         // last WAIT cycle
        n_cmp++;
        if ({cs_n, count, failed} !== {1'b0, 4'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL timeout_last_wait: got cs_n/count/failed=%b/%0d/%b want 0/1/0", cs_n, count, failed);
        end
        clear = 1'b1;                               // clear on the drop cycle
        tick();
        clear = 1'b0;
        n_cmp++;
        if ({cs_n, count, failed} !== {1'b1, 4'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL timeout_drop: got cs_n/count/failed=%b/%0d/%b want 1/0/1", cs_n, count, failed);
        end
        tick();
        n_cmp++;
        if (failed !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_sticky: got %b want 1", failed);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if (failed !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear: got %b want 0", failed);
        end
    endtask

    task automatic test_both_and_reset();
        bit seen;
        int cyc;
        wdata = 8'h77; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        wait_strobe(8, seen, cyc);
        tick();                                     // WAIT cycle 0
        complete = 1'b1; error = 1'b1;
        tick();
        complete = 1'b0; error = 1'b0;
        n_cmp++;
        if ({dv, cs_n, payload, count} !== {1'b1, 1'b0, 8'h77, 4'd1}) begin
            n_bad++;
            $display("FAIL both_retry: got dv/cs_n/payload/count=%b/%b/%h/%0d want 1/0/77/1",
                     dv, cs_n, payload, count);
        end
        repeat (2) tick();                          // WAIT cycle 1
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cs_n, dv, count, ready, aempty} !== {1'b1, 1'b0, 4'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL async_reset: got cs_n/dv/count/ready/ae=%b/%b/%0d/%b/%b want 1/0/0/1/1",
                     cs_n, dv, count, ready, aempty);
        end
        tick();
        rst_n = 1'b1;
        wait_strobe(6, seen, cyc);
        n_cmp++;
        if (seen || cs_n !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_idle: got strobe/cs_n=%b/%b want 0/1", seen, cs_n);
        end
        wdata = 8'h42; wvalid = 1'b1;
        tick();                                     // E0
        wvalid = 1'b0;
        tick();                                     // E1
        n_cmp++;
        if (cs_n !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_select: got cs_n=%b want 0", cs_n);
        end
        tick();                                     // E2
        n_cmp++;
        if ({dv, payload} !== {1'b1, 8'h42}) begin
            n_bad++;
            $display("FAIL post_reset_drive: got dv/payload=%b/%h want 1/42", dv, payload);
        end
        tick();
        complete = 1'b1;
        tick();
        complete = 1'b0;
        n_cmp++;
        if ({cs_n, count} !== {1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL post_reset_done: got cs_n/count=%b/%0d want 1/0", cs_n, count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_retry();
        test_timeout();
        test_both_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
